robot_cmd_arbiter: RTL and testbench
====================================

ROBOT_CMD_ARBITER -- requirements
Module: robot_cmd_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 50_000; idle clk cycles enforced after each message's last byte (0 = no gap).
REQ-002 Parameter WDOG_CYCLES, default 50_000_000; idle cycles after a non-STOP message before an automatic STOP (0 = disabled).
REQ-003 One clock; reset is asynchronous and active-high (ports clk and rst).
REQ-004 clk  input  1  system clock, 50 MHz.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  2  per-requester command request; bit 0 = IR remote, bit 1 = autonomous/vision; held until acked.
REQ-007 req_cmd0, req_cmd1  input  3 each  cmd_t command of requester 0/1: STOP=0, FWD=1, BWD=2, LEFT=3, RIGHT=4.
REQ-008 req_ack  output  2  one-cycle pulse; the matching request has been consumed.
REQ-009 tx_data  output  8  byte to uart_tx data_tx.
REQ-010 tx_valid  output  1  to uart_tx valid.
REQ-011 tx_ready  input  1  from uart_tx ready; a byte transfers on a cycle with tx_valid and tx_ready both high.
REQ-012 busy  output  1  high in SEND or GAP.
REQ-013 last_cmd  output  3  command of the most recently started message.

Function
REQ-014 FSM states IDLE, SEND, GAP; every message is exactly JSON_LEN=24 bytes, ending in 0x0A.
REQ-015 Message bytes: STOP {"T":1,"L":0.0,"R":0.0}, FWD L=0.1 R=0.1, BWD L=-.1 R=-.1, LEFT L=-.1 R=0.1, RIGHT L=0.1 R=-.1; negative values are encoded as "-.1", positive as "0.1".
REQ-016 Arbitration takes place in IDLE, and only there: a STOP from either requester wins, else requester 0, else requester 1.
REQ-017 If req_valid is sampled high in IDLE at cycle N, then at cycle N+1: req_ack pulses for the winner only, state = SEND, tx_valid=1, tx_data=byte 0, last_cmd updated.
REQ-018 The losing requester is not acked and keeps its request pending.
REQ-019 In SEND, tx_data and tx_valid stay stable until the transfer; byte index advances by one per transfer; there are no bubbles unless tx_ready is low.
REQ-020 On transfer of byte 23, tx_valid drops the next cycle; the FSM enters GAP, or IDLE if GAP_CYCLES=0.
REQ-021 GAP counts GAP_CYCLES cycles, then enters IDLE; requests are not acked in GAP.
REQ-022 A STOP request seen in SEND or GAP is acked the next cycle and sets stop_pending; further STOP requests while stop_pending is set are also acked and merged.
REQ-023 On entry to IDLE with stop_pending set, a STOP message starts the next cycle with no ack, stop_pending clears, and the STOP beats all other pending requests.
REQ-024 Non-STOP requests in SEND or GAP wait; they are never dropped and never acked early.
REQ-025 Watchdog counter clears when any message starts and counts only in IDLE.
REQ-026 Watchdog: when last_cmd != STOP and the count reaches WDOG_CYCLES, an internal STOP message starts with no ack; a req_valid in the same cycle takes precedence.
REQ-027 req_cmd codes 5-7 are acked and sent as STOP.
REQ-028 The in-progress message always completes; it is never truncated by new requests.

Reset
REQ-029 rst asserted: state = IDLE, tx_valid=0, tx_data=0x00, req_ack=0, busy=0, last_cmd=STOP, stop_pending=0, byte index=0, gap and watchdog counters=0; all take effect immediately (asynchronously).
REQ-030 Reset mid-message abandons the message; after release no byte is resent until a new request arrives.

Structure
REQ-031 Shared package robot_cmd_pkg: cmd_t enum, JSON_LEN, the req_cmd encodings, and the button-code constants EC13/FD02/F00F/EF10/FA05 used by the IR front end.
REQ-032 Sub-module robot_json_rom: combinational lookup from (cmd_t, index 0..23) to byte; the arbiter holds only the FSM, counters and pointer.

Verification
REQ-033 rst, then req_valid=01 with cmd0=FWD, tx_ready always 1 -> ack=01 at N+1; bytes 7B 22 54 22 3A 31 2C 22 4C 22 3A 30 2E 31 2C 22 52 22 3A 30 2E 31 7D 0A; then busy for GAP_CYCLES.
REQ-034 Both valid in IDLE, cmd0=LEFT, cmd1=RIGHT -> LEFT sent and ack=01; RIGHT sent after the gap and ack=10.
REQ-035 Both valid in IDLE, cmd0=FWD, cmd1=STOP -> STOP wins and ack=10.
REQ-036 During a FWD message requester 1 sends STOP and requester 0 sends BWD -> STOP acked immediately, FWD completes, STOP goes next, then BWD.
REQ-037 tx_ready low for 10 cycles at byte 5 -> tx_data=0x31 held for those 10 cycles; 24 bytes total, no duplicates.
REQ-038 WDOG_CYCLES=1000, single FWD, no further requests -> STOP starts 1000 idle cycles after the gap ends, with no ack.
REQ-039 rst asserted at byte 12 -> tx_valid=0 immediately, last_cmd=STOP, and the output stays silent after release.

Source files
------------

// File: rtl/robot_cmd_pkg.sv
// robot_cmd_pkg
// Definitions shared by the robot command path: the cmd_t motion command
// enum, the raw 3-bit req_cmd encodings, the fixed JSON message length, the
// IR remote button codes used by the IR front end, and a decoder that maps
// any raw request code onto a cmd_t.
// Ports: none (package).
package robot_cmd_pkg;

  typedef enum logic [2:0] {
    CMD_STOP  = 3'd0,
    CMD_FWD   = 3'd1,
    CMD_BWD   = 3'd2,
    CMD_LEFT  = 3'd3,
    CMD_RIGHT = 3'd4
  } cmd_t;

  // Every motor message is a fixed-length JSON line terminated by '\n'.
  localparam int JSON_LEN = 24;

  // Raw request encodings as driven on req_cmd0/req_cmd1.
  localparam logic [2:0] REQ_CMD_STOP  = 3'd0;
  localparam logic [2:0] REQ_CMD_FWD   = 3'd1;
  localparam logic [2:0] REQ_CMD_BWD   = 3'd2;
  localparam logic [2:0] REQ_CMD_LEFT  = 3'd3;
  localparam logic [2:0] REQ_CMD_RIGHT = 3'd4;

  // IR remote button codes recognised by the IR front end.
  localparam logic [15:0] IR_CODE_EC13 = 16'hEC13;
  localparam logic [15:0] IR_CODE_FD02 = 16'hFD02;
  localparam logic [15:0] IR_CODE_F00F = 16'hF00F;
  localparam logic [15:0] IR_CODE_EF10 = 16'hEF10;
  localparam logic [15:0] IR_CODE_FA05 = 16'hFA05;

  // Undefined codes (5..7) are treated as STOP, the safe choice for a robot.
  function automatic cmd_t decode_cmd(input logic [2:0] code);
    cmd_t c;
    case (code)
      REQ_CMD_FWD:   c = CMD_FWD;
      REQ_CMD_BWD:   c = CMD_BWD;
      REQ_CMD_LEFT:  c = CMD_LEFT;
      REQ_CMD_RIGHT: c = CMD_RIGHT;
      default:       c = CMD_STOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/robot_json_rom.sv
// robot_json_rom
// Combinational message table: returns byte idx of the JSON line for cmd,
// {"T":1,"L":<l>,"R":<r>}\n where each wheel value is "0.0", "0.1" or "-.1".
// Ports:
//   cmd  in  cmd_t  command whose message is being sent
//   idx  in  5      byte index 0..23
//   data out 8      message byte (0x00 for out-of-range index)
module robot_json_rom
  import robot_cmd_pkg::*;
(
  input  cmd_t       cmd,
  input  logic [4:0] idx,
  output logic [7:0] data
);

  localparam logic [1:0] W_ZERO = 2'd0;
  localparam logic [1:0] W_POS  = 2'd1;
  localparam logic [1:0] W_NEG  = 2'd2;

  logic [1:0] l_sel;
  logic [1:0] r_sel;

  // Three-character wheel field: sign/lead digit, '.', fraction digit.
  function automatic logic [7:0] wheel_char(input logic [1:0] sel, input logic [1:0] pos);
    logic [7:0] c;
    case (pos)
      2'd0:    c = (sel == W_NEG) ? 8'h2D : 8'h30;
      2'd1:    c = 8'h2E;
      default: c = (sel == W_ZERO) ? 8'h30 : 8'h31;
    endcase
    return c;
  endfunction

  always_comb begin
    l_sel = W_ZERO;
    r_sel = W_ZERO;
    data  = 8'h00;
    case (cmd)
      CMD_FWD:   begin l_sel = W_POS; r_sel = W_POS; end
      CMD_BWD:   begin l_sel = W_NEG; r_sel = W_NEG; end
      CMD_LEFT:  begin l_sel = W_NEG; r_sel = W_POS; end
      CMD_RIGHT: begin l_sel = W_POS; r_sel = W_NEG; end
      default:   ;
    endcase
    case (idx)
      5'd0:                data = 8'h7B;  // {
      5'd1, 5'd3:          data = 8'h22;  // "
      5'd2:                data = 8'h54;  // T
      5'd4, 5'd10, 5'd18:  data = 8'h3A;  // :
      5'd5:                data = 8'h31;  // 1
      5'd6, 5'd14:         data = 8'h2C;  // ,
      5'd7, 5'd9:          data = 8'h22;
      5'd8:                data = 8'h4C;  // L
      5'd11, 5'd12, 5'd13: data = wheel_char(l_sel, 2'(idx - 5'd11));
      5'd15, 5'd17:        data = 8'h22;
      5'd16:               data = 8'h52;  // R
      5'd19, 5'd20, 5'd21: data = wheel_char(r_sel, 2'(idx - 5'd19));
      5'd22:               data = 8'h7D;  // }
      5'd23:               data = 8'h0A;  // newline
      default:             data = 8'h00;
    endcase
  end

endmodule

// File: rtl/robot_cmd_arbiter.sv
// robot_cmd_arbiter
// Arbitrates between the IR remote (requester 0) and the autonomous/vision
// unit (requester 1), streams the winning command as a 24-byte JSON line to a
// UART transmitter, enforces an idle gap after every line, and issues an
// automatic STOP when a moving command has been left idle for too long.
// Ports:
//   clk        in  1   system clock (50 MHz)
//   rst        in  1   asynchronous active-high reset
//   req_valid  in  2   per-requester request, held until acked
//   req_cmd0/1 in  3   raw command code of requester 0/1
//   req_ack    out 2   one-cycle pulse, request consumed
//   tx_data    out 8   byte for the UART
//   tx_valid   out 1   byte valid for the UART
//   tx_ready   in  1   UART ready; transfer when tx_valid & tx_ready
//   busy       out 1   high while sending or in the post-message gap
//   last_cmd   out 3   command of the most recently started message
module robot_cmd_arbiter
  import robot_cmd_pkg::*;
#(
  parameter int unsigned GAP_CYCLES  = 50_000,
  parameter int unsigned WDOG_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic [2:0] req_cmd0,
  input  logic [2:0] req_cmd1,
  output logic [1:0] req_ack,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic [2:0] last_cmd
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  idx_reg, idx_next;
  cmd_t        last_cmd_reg, last_cmd_next;
  logic [31:0] gap_cnt_reg, gap_cnt_next;
  logic [31:0] wdog_cnt_reg, wdog_cnt_next;
  logic        stop_pending_reg, stop_pending_next;
  logic [1:0]  ack_reg, ack_next;

  cmd_t        cmd0, cmd1;
  logic [1:0]  pend;
  logic [1:0]  is_stop;
  logic        start_msg;
  cmd_t        start_cmd;
  logic [7:0]  rom_data;

  assign cmd0    = decode_cmd(req_cmd0);
  assign cmd1    = decode_cmd(req_cmd1);
  // A request whose ack is on the wire this cycle is already consumed.
  assign pend    = req_valid & ~ack_reg;
  assign is_stop = {cmd1 == CMD_STOP, cmd0 == CMD_STOP};

  // The message being sent is always that of last_cmd.
  robot_json_rom u_rom (
    .cmd  (last_cmd_reg),
    .idx  (idx_reg),
    .data (rom_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      idx_reg          <= '0;
      last_cmd_reg     <= CMD_STOP;
      gap_cnt_reg      <= '0;
      wdog_cnt_reg     <= '0;
      stop_pending_reg <= 1'b0;
      ack_reg          <= '0;
    end else begin
      state_reg        <= state_next;
      idx_reg          <= idx_next;
      last_cmd_reg     <= last_cmd_next;
      gap_cnt_reg      <= gap_cnt_next;
      wdog_cnt_reg     <= wdog_cnt_next;
      stop_pending_reg <= stop_pending_next;
      ack_reg          <= ack_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    idx_next          = idx_reg;
    last_cmd_next     = last_cmd_reg;
    gap_cnt_next      = gap_cnt_reg;
    wdog_cnt_next     = wdog_cnt_reg;
    stop_pending_next = stop_pending_reg;
    ack_next          = '0;
    start_msg         = 1'b0;
    start_cmd         = CMD_STOP;
    tx_valid          = 1'b0;
    tx_data           = 8'h00;
    busy              = 1'b1;

    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (stop_pending_reg) begin
          // A STOP merged during the previous message outranks everything.
          start_msg         = 1'b1;
          stop_pending_next = 1'b0;
        end else if (|pend) begin
          start_msg = 1'b1;
          if (pend[0] && is_stop[0]) begin
            start_cmd = cmd0;
            ack_next  = 2'b01;
          end else if (pend[1] && is_stop[1]) begin
            start_cmd = cmd1;
            ack_next  = 2'b10;
          end else if (pend[0]) begin
            start_cmd = cmd0;
            ack_next  = 2'b01;
          end else begin
            start_cmd = cmd1;
            ack_next  = 2'b10;
          end
        end else if (WDOG_CYCLES != 0 && last_cmd_reg != CMD_STOP) begin
          // This is idle cycle wdog_cnt+1; the STOP begins right after the
          // WDOG_CYCLES-th idle cycle.
          if (wdog_cnt_reg >= WDOG_CYCLES - 32'd1) begin
            start_msg = 1'b1;
          end else begin
            wdog_cnt_next = wdog_cnt_reg + 32'd1;
          end
        end
      end

      ST_SEND: begin
        tx_valid = 1'b1;
        tx_data  = rom_data;
        if (tx_ready) begin
          if (idx_reg == 5'(JSON_LEN - 1)) begin
            idx_next = '0;
            if (GAP_CYCLES == 0) begin
              state_next = ST_IDLE;
            end else begin
              state_next   = ST_GAP;
              gap_cnt_next = '0;
            end
          end else begin
            idx_next = idx_reg + 5'd1;
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_reg >= GAP_CYCLES - 32'd1) begin
          state_next   = ST_IDLE;
          gap_cnt_next = '0;
        end else begin
          gap_cnt_next = gap_cnt_reg + 32'd1;
        end
      end

      default: state_next = ST_IDLE;
    endcase

    // While busy, STOP requests are consumed at once and folded into a
    // single pending STOP; other requests simply wait for IDLE.
    if (state_reg != ST_IDLE) begin
      ack_next = pend & is_stop;
      if (|(pend & is_stop)) begin
        stop_pending_next = 1'b1;
      end
    end

    if (start_msg) begin
      state_next    = ST_SEND;
      idx_next      = '0;
      last_cmd_next = start_cmd;
      wdog_cnt_next = '0;
    end
  end

  assign req_ack  = ack_reg;
  assign last_cmd = last_cmd_reg;

endmodule

// File: tb/tb_robot_cmd_arbiter.sv
// tb_robot_cmd_arbiter
// Scoreboard bench for robot_cmd_arbiter: each scenario pushes the expected
// JSON bytes and ack pulses; a negedge monitor pops and compares them as the
// DUT transfers bytes and pulses acks.
module tb_robot_cmd_arbiter;
  import robot_cmd_pkg::*;

  localparam int unsigned GAP  = 20;
  localparam int unsigned WDOG = 1000;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [2:0] req_cmd0;
  logic [2:0] req_cmd1;
  logic [1:0] req_ack;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic [2:0] last_cmd;

  logic [7:0] exp_bytes[$];
  logic [1:0] exp_acks[$];
  int n_cmp = 0;
  int n_err = 0;
  int byte_cnt = 0;

  robot_cmd_arbiter #(.GAP_CYCLES(GAP), .WDOG_CYCLES(WDOG)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_cmd0  (req_cmd0),
    .req_cmd1  (req_cmd1),
    .req_ack   (req_ack),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .last_cmd  (last_cmd)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic string exp_msg(input int cmd);
    string l;
    string r;
    case (cmd)
      1:       begin l = "0.1"; r = "0.1"; end
      2:       begin l = "-.1"; r = "-.1"; end
      3:       begin l = "-.1"; r = "0.1"; end
      4:       begin l = "0.1"; r = "-.1"; end
      default: begin l = "0.0"; r = "0.0"; end
    endcase
    return {"{\"T\":1,\"L\":", l, ",\"R\":", r, "}\n"};
  endfunction

  task automatic push_msg(input int cmd);
    string s;
    s = exp_msg(cmd);
    for (int i = 0; i < s.len(); i++) exp_bytes.push_back(s[i]);
  endtask

  // Advance one cycle; requesters drop whatever was just acked.
  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~req_ack;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 2'b00;
    req_cmd0  = 3'd0;
    req_cmd1  = 3'd0;
    tx_ready  = 1'b1;
    exp_bytes.delete();
    exp_acks.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
  endtask

  // Run until all expected traffic is out and the DUT has idled a few cycles;
  // gap_cycles counts cycles spent busy without a byte on offer.
  task automatic wait_quiet(input string tag, output int gap_cycles);
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    gap_cycles = 0;
    while (quiet < 4 && n < 5000) begin
      tick();
      n++;
      if (busy && !tx_valid) gap_cycles++;
      if (!busy && !tx_valid && exp_bytes.size() == 0) quiet++;
      else quiet = 0;
    end
    chk({tag, "_bytes_left"}, 32'(exp_bytes.size()), 0);
    chk({tag, "_acks_left"}, 32'(exp_acks.size()), 0);
    chk({tag, "_busy_end"}, 32'(busy), 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      byte_cnt = 0;
    end else begin
      if (tx_valid && tx_ready) begin
        if (exp_bytes.size() == 0) chk("tx_valid_unexpected", 32'(tx_valid), 0);
        else chk("byte", 32'(tx_data), 32'(exp_bytes.pop_front()));
        byte_cnt++;
        if (byte_cnt == 24) begin
          $display("[tb] %0t message done, last_cmd=%0d last byte=%02h", $time, last_cmd, tx_data);
          byte_cnt = 0;
        end
      end
      if (req_ack != 2'b00) begin
        $display("[tb] %0t ack=%b", $time, req_ack);
        if (exp_acks.size() == 0) chk("ack_unexpected", 32'(req_ack), 0);
        else chk("ack", 32'(req_ack), 32'(exp_acks.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int gaps;
    int n;
    int idle;
    int silent;

    // Reset state.
    rst = 1'b1; req_valid = 2'b00; req_cmd0 = 3'd0; req_cmd1 = 3'd0; tx_ready = 1'b1;
    #5;
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_ack", 32'(req_ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_last_cmd", 32'(last_cmd), 0);

    // Single FWD: ack and first byte one cycle after sampling, then gap.
    do_reset();
    req_cmd0 = 3'd1; req_valid = 2'b01;
    push_msg(1); exp_acks.push_back(2'b01);
    tick();
    chk("fwd_ack_n1", 32'(req_ack), 32'h1);
    chk("fwd_tx_valid_n1", 32'(tx_valid), 1);
    chk("fwd_byte0_n1", 32'(tx_data), 32'h7B);
    chk("fwd_last_cmd", 32'(last_cmd), 1);
    wait_quiet("fwd", gaps);
    chk("fwd_gap_len", 32'(gaps), GAP);

    // LEFT vs RIGHT: requester 0 first, RIGHT after the gap.
    do_reset();
    req_cmd0 = 3'd3; req_cmd1 = 3'd4; req_valid = 2'b11;
    push_msg(3); push_msg(4);
    exp_acks.push_back(2'b01); exp_acks.push_back(2'b10);
    tick();
    chk("lr_last_cmd", 32'(last_cmd), 3);
    wait_quiet("lr", gaps);
    chk("lr_gap_len", 32'(gaps), 2 * GAP);

    // FWD vs STOP: STOP wins, FWD follows.
    do_reset();
    req_cmd0 = 3'd1; req_cmd1 = 3'd0; req_valid = 2'b11;
    push_msg(0); push_msg(1);
    exp_acks.push_back(2'b10); exp_acks.push_back(2'b01);
    tick();
    chk("stopwin_ack", 32'(req_ack), 32'h2);
    chk("stopwin_last_cmd", 32'(last_cmd), 0);
    wait_quiet("stopwin", gaps);

    // STOP and BWD arrive mid-FWD: STOP acked now, sent after FWD, then BWD.
    do_reset();
    req_cmd0 = 3'd1; req_valid = 2'b01;
    push_msg(1); exp_acks.push_back(2'b01);
    tick();
    repeat (5) tick();
    req_cmd0 = 3'd2; req_cmd1 = 3'd0; req_valid = 2'b11;
    push_msg(0); push_msg(2);
    exp_acks.push_back(2'b10); exp_acks.push_back(2'b01);
    tick();
    chk("midstop_ack_now", 32'(req_ack), 32'h2);
    chk("midstop_fwd_continues", 32'(last_cmd), 1);
    wait_quiet("midstop", gaps);

    // Back-pressure at byte 5.
    do_reset();
    req_cmd0 = 3'd1; req_valid = 2'b01;
    push_msg(1); exp_acks.push_back(2'b01);
    tick();
    repeat (5) tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_data", 32'(tx_data), 32'h31);
      chk("stall_valid", 32'(tx_valid), 1);
    end
    tx_ready = 1'b1;
    wait_quiet("stall", gaps);

    // Undefined code 7 is acked and sent as STOP.
    do_reset();
    req_cmd1 = 3'd7; req_valid = 2'b10;
    push_msg(0); exp_acks.push_back(2'b10);
    tick();
    chk("code7_last_cmd", 32'(last_cmd), 0);
    wait_quiet("code7", gaps);

    // Reset at byte 12: output dies immediately and stays silent.
    do_reset();
    req_cmd0 = 3'd1; req_valid = 2'b01;
    push_msg(1); exp_acks.push_back(2'b01);
    tick();
    repeat (12) tick();
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_tx_valid", 32'(tx_valid), 0);
    chk("midrst_last_cmd", 32'(last_cmd), 0);
    chk("midrst_busy", 32'(busy), 0);
    exp_bytes.delete();
    exp_acks.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    silent = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx_valid) silent++;
    end
    chk("midrst_silent", 32'(silent), 0);

    // Watchdog: STOP after WDOG idle cycles, no ack.
    do_reset();
    req_cmd0 = 3'd1; req_valid = 2'b01;
    push_msg(1); push_msg(0); exp_acks.push_back(2'b01);
    tick();
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("wdog_gap_end", 32'(busy), 0);
    idle = 1;
    n = 0;
    while (n < 3000) begin
      tick();
      n++;
      if (tx_valid) break;
      idle++;
    end
    chk("wdog_idle_cycles", 32'(idle), WDOG);
    chk("wdog_last_cmd", 32'(last_cmd), 0);
    wait_quiet("wdog", gaps);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
